// File: rtl/red_pitaya_iq_modulator_ramp_block_if.sv
// Gain-control bus for the IQ modulator: target gains, load/ramp controls and status.
interface red_pitaya_iq_modulator_ramp_block_if #(
    parameter int GAINBITS = 16
);
    logic signed [GAINBITS-1:0] g1_i;
    logic signed [GAINBITS-1:0] g2_i;
    logic signed [GAINBITS-1:0] g3_i;
    logic signed [GAINBITS-1:0] g4_i;
    logic                       gain_load_i;
    logic        [GAINBITS-2:0] ramp_step_i;
    logic                       clear_ovf_i;
    logic                       ramp_busy_o;
    logic        [2:0]          ovf_o;

    modport master (
        output g1_i, g2_i, g3_i, g4_i, gain_load_i, ramp_step_i, clear_ovf_i,
        input  ramp_busy_o, ovf_o
    );

    modport slave (
        input  g1_i, g2_i, g3_i, g4_i, gain_load_i, ramp_step_i, clear_ovf_i,
        output ramp_busy_o, ovf_o
    );
endinterface

// File: rtl/red_pitaya_iq_modulator_ramp_block.sv
// IQ modulator with ramped gain updates: I/Q scaling, LO mixing, saturation and
// sticky overflow reporting in a three-stage pipeline.
module red_pitaya_iq_modulator_ramp_block #(
    parameter int INBITS    = 18,
    parameter int OUTBITS   = 14,
    parameter int SINBITS   = 14,
    parameter int GAINBITS  = 16,
    parameter int SHIFTBITS = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic signed [SINBITS-1:0] sin,
    input  logic signed [SINBITS-1:0] cos,
    input  logic signed [INBITS-1:0]  signal1_i,
    input  logic signed [INBITS-1:0]  signal2_i,
    output logic signed [OUTBITS-1:0] dat_o,
    output logic signed [OUTBITS-1:0] signal_q1_o,
    output logic signed [OUTBITS-1:0] signal_q2_o,
    red_pitaya_iq_modulator_ramp_block_if.slave ctrl
);
    localparam int PW = GAINBITS + INBITS + 2;
    localparam int SH = GAINBITS + INBITS - OUTBITS - SHIFTBITS;
    localparam int SW = OUTBITS + SINBITS + 1;
    localparam logic signed [PW-1:0] P_MAX = PW'(2**(OUTBITS-1) - 1);
    localparam logic signed [PW-1:0] P_MIN = ~P_MAX;
    localparam logic signed [SW-1:0] S_MAX = SW'(2**(OUTBITS-1) - 1);
    localparam logic signed [SW-1:0] S_MIN = ~S_MAX;

    typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

    state_t state_reg, state_next;
    logic   busy_reg;

    // Index order: 0 = I amplitude, 1 = I offset, 2 = quadrature monitor, 3 = Q amplitude
    logic signed [GAINBITS-1:0] g_in       [4];
    logic signed [GAINBITS-1:0] g_act_reg  [4];
    logic signed [GAINBITS-1:0] g_act_next [4];
    logic signed [GAINBITS-1:0] g_tgt_reg  [4];
    logic signed [GAINBITS-1:0] g_tgt_next [4];
    logic signed [GAINBITS-1:0] g_step     [4];
    logic        [3:0]          g_match;
    logic signed [GAINBITS:0]   step_ext;
    logic signed [GAINBITS-1:0] step_g;

    assign g_in[0]  = ctrl.g1_i;
    assign g_in[1]  = ctrl.g2_i;
    assign g_in[2]  = ctrl.g3_i;
    assign g_in[3]  = ctrl.g4_i;
    assign step_ext = signed'({2'b00, ctrl.ramp_step_i});
    assign step_g   = signed'({1'b0, ctrl.ramp_step_i});

    // Each gain steps toward its target; the final step lands exactly on the target.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ramp
            logic signed [GAINBITS:0] diff;
            assign diff = {g_tgt_reg[gi][GAINBITS-1], g_tgt_reg[gi]}
                        - {g_act_reg[gi][GAINBITS-1], g_act_reg[gi]};
            assign g_step[gi] = (diff > step_ext)  ? g_act_reg[gi] + step_g :
                                (diff < -step_ext) ? g_act_reg[gi] - step_g :
                                                     g_tgt_reg[gi];
            assign g_match[gi] = (g_step[gi] == g_tgt_reg[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        g_act_next = g_act_reg;
        g_tgt_next = g_tgt_reg;
        if (ctrl.gain_load_i) begin
            g_tgt_next = g_in;
            if (ctrl.ramp_step_i == '0) begin
                g_act_next = g_in;
                state_next = IDLE;
            end else begin
                state_next = RAMP;
            end
        end else if (state_reg == RAMP) begin
            g_act_next = g_step;
            if (&g_match) state_next = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                g_act_reg[i] <= '0;
                g_tgt_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RAMP);
            g_act_reg <= g_act_next;
            g_tgt_reg <= g_tgt_next;
        end
    end

    // Floor-slice a full-width product to OUTBITS, clamping at the rails.
    function automatic logic signed [OUTBITS-1:0] slice_val(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sh;
        sh = p >>> SH;
        if (sh > P_MAX)      slice_val = P_MAX[OUTBITS-1:0];
        else if (sh < P_MIN) slice_val = P_MIN[OUTBITS-1:0];
        else                 slice_val = sh[OUTBITS-1:0];
    endfunction

    function automatic logic slice_ovf(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sh;
        sh = p >>> SH;
        slice_ovf = (sh > P_MAX) || (sh < P_MIN);
    endfunction

    logic signed [PW-1:0] p1_full, p2_full, q1_full, q2_full;
    assign p1_full = PW'(signal1_i) * PW'(g_act_reg[0]) + (PW'(g_act_reg[1]) <<< (INBITS + 1));
    assign p2_full = PW'(signal2_i) * PW'(g_act_reg[3]);
    assign q1_full = PW'(signal1_i) * PW'(g_act_reg[2]);
    assign q2_full = PW'(signal2_i) * PW'(g_act_reg[2]);

    logic signed [OUTBITS-1:0] p1_reg, p2_reg, q1_reg, q2_reg;
    logic signed [OUTBITS-1:0] q1_out_reg, q2_out_reg, dat_reg;
    logic signed [SINBITS-1:0] sin_d, cos_d;
    logic signed [SW-1:0]      s_reg, s_next, s_sh;
    logic signed [OUTBITS-1:0] dat_next;
    logic                      s_hi, s_lo;
    logic        [2:0]         ovf_reg, ovf_next;

    assign s_next   = SW'(p1_reg) * SW'(sin_d) + SW'(p2_reg) * SW'(cos_d);
    assign s_sh     = s_reg >>> SINBITS;
    assign s_hi     = (s_sh > S_MAX);
    assign s_lo     = (s_sh < S_MIN);
    assign dat_next = s_hi ? S_MAX[OUTBITS-1:0] :
                      s_lo ? S_MIN[OUTBITS-1:0] : s_sh[OUTBITS-1:0];

    // A fresh overflow in the clearing cycle keeps its flag set.
    assign ovf_next = (ovf_reg & {3{~ctrl.clear_ovf_i}})
                    | {s_hi | s_lo, slice_ovf(p2_full), slice_ovf(p1_full)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p1_reg     <= '0;
            p2_reg     <= '0;
            q1_reg     <= '0;
            q2_reg     <= '0;
            q1_out_reg <= '0;
            q2_out_reg <= '0;
            sin_d      <= '0;
            cos_d      <= '0;
            s_reg      <= '0;
            dat_reg    <= '0;
            ovf_reg    <= '0;
        end else begin
            p1_reg     <= slice_val(p1_full);
            p2_reg     <= slice_val(p2_full);
            q1_reg     <= slice_val(q1_full);
            q2_reg     <= slice_val(q2_full);
            q1_out_reg <= q1_reg;
            q2_out_reg <= q2_reg;
            sin_d      <= sin;
            cos_d      <= cos;
            s_reg      <= s_next;
            dat_reg    <= dat_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign dat_o            = dat_reg;
    assign signal_q1_o      = q1_out_reg;
    assign signal_q2_o      = q2_out_reg;
    assign ctrl.ramp_busy_o = busy_reg;
    assign ctrl.ovf_o       = ovf_reg;
endmodule
